// File: rtl/trbuf_pkg.sv
// Shared types for the instruction-trace buffer: capture modes and control states.
package trbuf_pkg;

  typedef enum logic [1:0] {
    LINEAR   = 2'd0,
    CIRC     = 2'd1,
    TRIGSTOP = 2'd2,
    OFF      = 2'd3
  } trmode_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    POST = 2'd1,
    STOP = 2'd2
  } trstate_t;

endpackage

// File: rtl/trbuf_if.sv
// Console/CPU-side signal bundle of the trace buffer.
interface trbuf_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024
);
  localparam int PTRW = $clog2(DEPTH);

  logic              cpuVALID;
  logic [WIDTH-1:0]  cpuITR;
  logic [WIDTH-1:0]  cpuPCIR;
  logic              trTRIG;
  logic [1:0]        trMODE;
  logic [PTRW:0]     trPOST;
  logic              trCLR;
  logic              trADV;
  logic [WIDTH-1:0]  trITR;
  logic [WIDTH-1:0]  trPCIR;
  logic [PTRW:0]     trCOUNT;
  logic              trEMPTY;
  logic              trFULL;
  logic              trOVFL;
  logic              trDONE;

  modport master (
    output cpuVALID, cpuITR, cpuPCIR, trTRIG, trMODE, trPOST, trCLR, trADV,
    input  trITR, trPCIR, trCOUNT, trEMPTY, trFULL, trOVFL, trDONE
  );

  modport slave (
    input  cpuVALID, cpuITR, cpuPCIR, trTRIG, trMODE, trPOST, trCLR, trADV,
    output trITR, trPCIR, trCOUNT, trEMPTY, trFULL, trOVFL, trDONE
  );
endinterface

// File: rtl/trbuf_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port, no reset.
// A read of the address being written returns the old contents.
module trbuf_ram #(
  parameter int DW    = 128,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_q
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port and synchronous read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

endmodule

// File: rtl/trbuf.sv
// Instruction-trace buffer: captures {ITR, PCIR} per retired instruction in
// linear, circular or trigger-stop mode; console drains oldest-first.
module trbuf
  import trbuf_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst,
  trbuf_if.slave bus
);

  localparam logic [PTRW:0]   FULL_CNT = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = {{PTRW{1'b0}}, 1'b1};
  localparam logic [PTRW-1:0] PTR_ONE  = {{(PTRW-1){1'b0}}, 1'b1};

  trmode_t            mode_q, mode_d;
  trstate_t           state_q, state_d;
  logic [PTRW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PTRW:0]      count_q, count_d, rem_q, rem_d;
  logic               ovfl_q, ovfl_d, full_q, full_d, done_q, done_d;
  logic               empty_q, empty_d, ld_q, ld_d, byp_sel_q, byp_sel_d;
  logic [2*WIDTH-1:0] byp_q, byp_d, head_q, head_d;
  logic [2*WIDTH-1:0] wdata_s, ram_rdata_s;
  logic               store_s, adv_s, is_full_s;

  assign wdata_s = {bus.cpuITR, bus.cpuPCIR};

  trbuf_ram #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTRW)
  ) u_ram (
    .clk     (clk),
    .we      (store_s),
    .waddr   (wr_q),
    .wdata   (wdata_s),
    .raddr   (rd_d),
    .rdata_q (ram_rdata_s)
  );

  // Next-state, pointer, count and head-pipeline logic.
  always_comb begin
    mode_d    = mode_q;
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    rem_d     = rem_q;
    ovfl_d    = ovfl_q;
    ld_d      = 1'b0;
    byp_sel_d = 1'b0;
    byp_d     = byp_q;
    store_s   = 1'b0;
    is_full_s = (count_q == FULL_CNT);

    if (bus.trCLR || state_q == STOP) begin
      store_s = 1'b0;
    end else if (mode_q == LINEAR) begin
      store_s = bus.cpuVALID && !is_full_s;
    end else if (mode_q == CIRC || mode_q == TRIGSTOP) begin
      store_s = bus.cpuVALID;
    end else begin
      store_s = 1'b0;
    end
    adv_s = bus.trADV && (count_q != '0) && !bus.trCLR;

    if (bus.trCLR) begin
      mode_d  = trmode_t'(bus.trMODE);
      state_d = (trmode_t'(bus.trMODE) == OFF) ? STOP : RUN;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      rem_d   = '0;
      ovfl_d  = 1'b0;
    end else begin
      if (store_s) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      // A pop and an overwrite in the same cycle retire the same oldest entry.
      if (adv_s || (store_s && is_full_s)) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
      if (store_s && !adv_s) begin
        if (is_full_s) begin
          ovfl_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else if (!store_s && adv_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end

      case (state_q)
        RUN: begin
          if (mode_q == LINEAR && count_d == FULL_CNT) begin
            state_d = STOP;
          end else if (mode_q == TRIGSTOP && bus.trTRIG) begin
            rem_d   = bus.trPOST;
            state_d = (bus.trPOST == '0) ? STOP : POST;
          end else begin
            state_d = RUN;
          end
        end
        POST: begin
          if (store_s) begin
            rem_d   = rem_q - CNT_ONE;
            state_d = (rem_q == CNT_ONE) ? STOP : POST;
          end else begin
            state_d = POST;
          end
        end
        STOP:    state_d = STOP;
        default: state_d = STOP;
      endcase

      ld_d      = (rd_d != rd_q) || (store_s && count_q == '0);
      byp_sel_d = store_s && (wr_q == rd_d);
      byp_d     = wdata_s;
    end

    if (ld_q) begin
      head_d = byp_sel_q ? byp_q : ram_rdata_s;
    end else begin
      head_d = head_q;
    end

    // Empty follows the head pipeline on fill but asserts immediately on drain.
    if (count_d == '0) begin
      empty_d = 1'b1;
    end else if (ld_q) begin
      empty_d = 1'b0;
    end else begin
      empty_d = empty_q;
    end

    full_d = (count_d == FULL_CNT);
    done_d = (state_d == STOP);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= OFF;
      state_q   <= STOP;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      ovfl_q    <= 1'b0;
      full_q    <= 1'b0;
      done_q    <= 1'b1;
      empty_q   <= 1'b1;
      ld_q      <= 1'b0;
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
      head_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      ovfl_q    <= ovfl_d;
      full_q    <= full_d;
      done_q    <= done_d;
      empty_q   <= empty_d;
      ld_q      <= ld_d;
      byp_sel_q <= byp_sel_d;
      byp_q     <= byp_d;
      head_q    <= head_d;
    end
  end

  assign bus.trITR   = head_q[2*WIDTH-1:WIDTH];
  assign bus.trPCIR  = head_q[WIDTH-1:0];
  assign bus.trCOUNT = count_q;
  assign bus.trEMPTY = empty_q;
  assign bus.trFULL  = full_q;
  assign bus.trOVFL  = ovfl_q;
  assign bus.trDONE  = done_q;

endmodule

// File: tb/tb_trbuf.sv
// Directed bench for trbuf with DEPTH=8, WIDTH=64.
module tb_trbuf;
  import trbuf_pkg::*;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  trbuf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  trbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input int val);
    bus.cpuVALID = 1'b1;
    bus.cpuITR   = 64'(val);
    bus.cpuPCIR  = 64'(val) + 64'h100;
  endtask

  task automatic push(input int val);
    drive_sample(val);
    tick();
    bus.cpuVALID = 1'b0;
  endtask

  task automatic clear(input logic [1:0] mode);
    bus.trCLR  = 1'b1;
    bus.trMODE = mode;
    tick();
    bus.trCLR  = 1'b0;
  endtask

  task automatic drain(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_itr"}, bus.trITR, 64'(first + i));
      check({tag, "_pcir"}, bus.trPCIR, 64'(first + i) + 64'h100);
      bus.trADV = 1'b1;
      tick();
      bus.trADV = 1'b0;
      tick();
      tick();
    end
    check({tag, "_empty"}, {63'd0, bus.trEMPTY}, 64'd1);
    check({tag, "_count0"}, 64'(bus.trCOUNT), 64'd0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b0;
    bus.cpuVALID = 1'b0;
    bus.cpuITR   = 64'd0;
    bus.cpuPCIR  = 64'd0;
    bus.trTRIG   = 1'b0;
    bus.trMODE   = 2'd0;
    bus.trPOST   = 4'd0;
    bus.trCLR    = 1'b0;
    bus.trADV    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    check("rst_count", 64'(bus.trCOUNT), 64'd0);
    check("rst_empty", {63'd0, bus.trEMPTY}, 64'd1);
    check("rst_full", {63'd0, bus.trFULL}, 64'd0);
    check("rst_ovfl", {63'd0, bus.trOVFL}, 64'd0);
    check("rst_done", {63'd0, bus.trDONE}, 64'd1);
    check("rst_itr", bus.trITR, 64'd0);

    // No capture before the first clear.
    for (int i = 1; i <= 3; i++) push(i);
    tick();
    check("noclr_count", 64'(bus.trCOUNT), 64'd0);
    check("noclr_empty", {63'd0, bus.trEMPTY}, 64'd1);
    check("noclr_done", {63'd0, bus.trDONE}, 64'd1);

    // Linear: stops at full, extra samples dropped.
    clear(LINEAR);
    check("lin_done_clr", {63'd0, bus.trDONE}, 64'd0);
    for (int i = 1; i <= 10; i++) begin
      push(i);
      if (i == 7) check("lin_full7", {63'd0, bus.trFULL}, 64'd0);
      if (i == 8) begin
        check("lin_full8", {63'd0, bus.trFULL}, 64'd1);
        check("lin_done8", {63'd0, bus.trDONE}, 64'd1);
      end
    end
    tick();
    check("lin_count", 64'(bus.trCOUNT), 64'd8);
    check("lin_full", {63'd0, bus.trFULL}, 64'd1);
    check("lin_done", {63'd0, bus.trDONE}, 64'd1);
    drain("lin", 1, 8);
    check("lin_ovfl", {63'd0, bus.trOVFL}, 64'd0);

    // Circular: oldest three overwritten.
    clear(CIRC);
    for (int i = 1; i <= 11; i++) push(i);
    tick();
    check("circ_count", 64'(bus.trCOUNT), 64'd8);
    check("circ_ovfl", {63'd0, bus.trOVFL}, 64'd1);
    check("circ_done", {63'd0, bus.trDONE}, 64'd0);
    drain("circ", 4, 8);

    // Full circular buffer: pop and store in one cycle.
    clear(CIRC);
    for (int i = 1; i <= 8; i++) push(i);
    tick();
    check("both_head_pre", bus.trITR, 64'd1);
    drive_sample(9);
    bus.trADV = 1'b1;
    tick();
    bus.cpuVALID = 1'b0;
    bus.trADV    = 1'b0;
    check("both_count", 64'(bus.trCOUNT), 64'd8);
    check("both_ovfl", {63'd0, bus.trOVFL}, 64'd0);
    check("both_full", {63'd0, bus.trFULL}, 64'd1);
    tick();
    tick();
    drain("both", 2, 8);

    // Trigger-stop with two post-trigger samples.
    bus.trPOST = 4'd2;
    clear(TRIGSTOP);
    for (int i = 1; i <= 5; i++) push(i);
    bus.trTRIG = 1'b1;
    push(6);
    bus.trTRIG = 1'b0;
    check("trig_done6", {63'd0, bus.trDONE}, 64'd0);
    push(7);
    check("trig_done7", {63'd0, bus.trDONE}, 64'd0);
    push(8);
    check("trig_done8", {63'd0, bus.trDONE}, 64'd1);
    for (int i = 9; i <= 12; i++) push(i);
    tick();
    check("trig_count", 64'(bus.trCOUNT), 64'd8);
    check("trig_ovfl", {63'd0, bus.trOVFL}, 64'd0);
    drain("trig", 1, 8);

    // Clear wins over a same-cycle sample.
    clear(CIRC);
    for (int i = 1; i <= 3; i++) push(i);
    drive_sample(50);
    clear(CIRC);
    bus.cpuVALID = 1'b0;
    check("clrv_count", 64'(bus.trCOUNT), 64'd0);
    check("clrv_empty", {63'd0, bus.trEMPTY}, 64'd1);
    check("clrv_done", {63'd0, bus.trDONE}, 64'd0);
    tick();
    tick();
    check("clrv_count2", 64'(bus.trCOUNT), 64'd0);

    // Asynchronous reset while in POST.
    bus.trPOST = 4'd4;
    clear(TRIGSTOP);
    push(1);
    bus.trTRIG = 1'b1;
    push(2);
    bus.trTRIG = 1'b0;
    push(3);
    tick();
    check("post_count", 64'(bus.trCOUNT), 64'd3);
    check("post_done", {63'd0, bus.trDONE}, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(bus.trCOUNT), 64'd0);
    check("arst_done", {63'd0, bus.trDONE}, 64'd1);
    check("arst_empty", {63'd0, bus.trEMPTY}, 64'd1);
    check("arst_itr", bus.trITR, 64'd0);
    check("arst_pcir", bus.trPCIR, 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) push(i);
    tick();
    check("arst_nocap", 64'(bus.trCOUNT), 64'd0);
    check("arst_done2", {63'd0, bus.trDONE}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
